// File: rtl/imm_ext_builder_pkg.sv
// imm_pkg: shared mode/state encodings and sizing helper for the immediate-extension unit.
package imm_pkg;
    localparam logic [1:0] IMM_ZEXT = 2'b00;
    localparam logic [1:0] IMM_SEXT = 2'b01;
    localparam logic [1:0] IMM_PFX  = 2'b10;
    localparam logic [1:0] IMM_CLR  = 2'b11;
    typedef enum logic {IDLE, ACCUM} state_t;
    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction
endpackage

// File: rtl/imm_extend_comb.sv
// imm_extend_comb: extends a right-aligned value of live width i_n to OUT_W bits, zero or sign fill.
module imm_extend_comb #(
    parameter int N_MAX = 10,
    parameter int OUT_W = 8
) (
    input  logic [N_MAX-1:0]           i_c,
    input  logic [$clog2(N_MAX+1)-1:0] i_n,
    input  logic                       i_sext,
    output logic [OUT_W-1:0]           o_ext
);
    logic w_msb;
    always_comb begin
        w_msb = 1'b0;
        for (int i = 0; i < N_MAX; i++) w_msb = (i == int'(i_n) - 1) ? i_c[i] : w_msb;
        o_ext = i_c[OUT_W-1:0];
        for (int i = 0; i < OUT_W; i++) o_ext[i] = (i_sext && i >= int'(i_n)) ? w_msb : o_ext[i];
    end
endmodule

// File: rtl/imm_ext_builder.sv
// imm_ext_builder: registered immediate extender with multi-chunk prefix accumulation
// and valid/ready handshakes on both sides.
module imm_ext_builder
    import imm_pkg::*;
#(
    parameter int IN_W  = 5,
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_mode,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf
);
    localparam int MAX_PREFIX = ceil_div(OUT_W, IN_W) - 1;
    localparam int ACC_W      = (MAX_PREFIX > 0 ? MAX_PREFIX : 1) * IN_W;
    localparam int N_MAX      = ACC_W + IN_W;
    localparam int PC_W       = $clog2(MAX_PREFIX + 2);
    localparam int NW         = $clog2(N_MAX + 1);

    state_t           r_state, w_state_n;
    logic [ACC_W-1:0] r_acc, w_acc_n;
    logic [PC_W-1:0]  r_pcount, w_pcount_n;
    logic             r_lost, w_lost_n;
    logic             w_take, w_ext, w_full;
    logic [NW-1:0]    w_n;
    logic [OUT_W-1:0] w_ext_data;

    assign in_ready = !out_valid || out_ready;
    assign w_take   = in_valid && in_ready;
    assign w_ext    = w_take && !in_mode[1];
    assign w_full   = int'(r_pcount) == MAX_PREFIX;
    // acc bits above pcount*IN_W are always zero, so {acc, in_data} is C right-aligned
    assign w_n      = (r_state == IDLE) ? NW'(IN_W) : NW'((int'(r_pcount) + 1) * IN_W);

    imm_extend_comb #(.N_MAX(N_MAX), .OUT_W(OUT_W)) u_ext (
        .i_c    ({r_acc, in_data}),
        .i_n    (w_n),
        .i_sext (in_mode == IMM_SEXT),
        .o_ext  (w_ext_data)
    );

    always_comb begin
        w_state_n  = r_state;
        w_acc_n    = r_acc;
        w_pcount_n = r_pcount;
        w_lost_n   = r_lost;
        if (w_take && in_mode == IMM_PFX) begin
            w_acc_n    = ACC_W'({r_acc, in_data});
            w_pcount_n = w_full ? r_pcount : r_pcount + 1'b1;
            w_lost_n   = r_lost || w_full;
            w_state_n  = ACCUM;
        end else if (w_take) begin
            w_acc_n    = '0;
            w_pcount_n = '0;
            w_lost_n   = 1'b0;
            w_state_n  = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_acc     <= '0;
            r_pcount  <= '0;
            r_lost    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_acc    <= w_acc_n;
            r_pcount <= w_pcount_n;
            r_lost   <= w_lost_n;
            if (w_ext) begin
                out_valid <= 1'b1;
                out_data  <= w_ext_data;
                out_ovf   <= r_lost;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_imm_ext_builder.sv
// tb_imm_ext_builder: directed checks of imm_ext_builder at OUT_W=8 and OUT_W=16.
module tb_imm_ext_builder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [1:0]  in_mode = 2'b00;
    logic [4:0]  in_data = '0;
    logic        out_ready = 1'b1;
    logic        in_ready, out_valid, out_ovf;
    logic [7:0]  out_data;
    logic        in_ready16, out_valid16, out_ovf16;
    logic [15:0] out_data16;
    int          n_pass = 0;
    int          n_chk = 0;

    always #5 clk = ~clk;

    imm_ext_builder #(.IN_W(5), .OUT_W(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf)
    );

    imm_ext_builder #(.IN_W(5), .OUT_W(16)) dut16 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready16),
        .in_mode(in_mode), .in_data(in_data), .out_valid(out_valid16),
        .out_ready(1'b1), .out_data(out_data16), .out_ovf(out_ovf16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic send(input logic [1:0] mode, input logic [4:0] data);
        in_valid = 1'b1;
        in_mode  = mode;
        in_data  = data;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    logic [4:0] b2b_in  [4] = '{5'h01, 5'h1E, 5'h0F, 5'h10};
    logic [7:0] b2b_exp [4] = '{8'h01, 8'hFE, 8'h0F, 8'hF0};

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_data", 32'(out_data), 32'h0);
        chk("rst_ovf", 32'(out_ovf), 32'h0);
        chk("rst_ready", 32'(in_ready), 32'h1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        send(2'b01, 5'b11111);
        chk("sext_1f_valid", 32'(out_valid), 32'h1);
        chk("sext_1f", 32'(out_data), 32'hFF);
        chk("sext_1f_ovf", 32'(out_ovf), 32'h0);
        send(2'b00, 5'b10000);
        chk("zext_10_valid", 32'(out_valid), 32'h1);
        chk("zext_10", 32'(out_data), 32'h10);
        send(2'b01, 5'b10000);
        chk("sext_10", 32'(out_data), 32'hF0);
        chk("sext_10_ovf", 32'(out_ovf), 32'h0);
        send(2'b10, 5'b10000);
        chk("w16_pfx_novalid", 32'(out_valid16), 32'h0);
        send(2'b01, 5'b00001);
        chk("w16_sext_valid", 32'(out_valid16), 32'h1);
        chk("w16_sext", 32'(out_data16), 32'hFE01);
        chk("w16_sext_ovf", 32'(out_ovf16), 32'h0);
        send(2'b10, 5'b10000);
        send(2'b00, 5'b00001);
        chk("w16_zext", 32'(out_data16), 32'h0201);
        send(2'b10, 5'b00001);
        chk("ovp_pfx_novalid", 32'(out_valid), 32'h0);
        send(2'b10, 5'b00011);
        send(2'b00, 5'b00101);
        chk("ovp_data", 32'(out_data), 32'h65);
        chk("ovp_ovf", 32'(out_ovf), 32'h1);
        send(2'b00, 5'b00001);
        chk("ovp_next_data", 32'(out_data), 32'h01);
        chk("ovp_next_ovf", 32'(out_ovf), 32'h0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 2'b00;
        in_data   = 5'b00111;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("bp_ready", 32'(in_ready), 32'h0);
            chk("bp_valid", 32'(out_valid), 32'h1);
            chk("bp_hold", 32'(out_data), 32'h01);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'h1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_reload_valid", 32'(out_valid), 32'h1);
        chk("bp_reload_data", 32'(out_data), 32'h07);
        @(posedge clk);
        #1;
        chk("bp_drain", 32'(out_valid), 32'h0);
        send(2'b10, 5'b11111);
        send(2'b11, 5'b00000);
        chk("clr_novalid", 32'(out_valid), 32'h0);
        send(2'b01, 5'b00010);
        chk("clr_sext", 32'(out_data), 32'h02);
        chk("clr_ovf", 32'(out_ovf), 32'h0);
        send(2'b10, 5'b11111);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_mode  = 2'b01;
        in_data  = 5'b11111;
        @(posedge clk);
        #1;
        chk("midrst_valid", 32'(out_valid), 32'h0);
        chk("midrst_data", 32'(out_data), 32'h0);
        chk("midrst_ovf", 32'(out_ovf), 32'h0);
        reset    = 1'b0;
        in_valid = 1'b0;
        send(2'b01, 5'b00010);
        chk("postrst_sext", 32'(out_data), 32'h02);
        chk("postrst_ovf", 32'(out_ovf), 32'h0);
        in_valid = 1'b1;
        in_mode  = 2'b01;
        for (int i = 0; i < 4; i++) begin
            in_data = b2b_in[i];
            @(posedge clk);
            #1;
            chk("b2b_valid", 32'(out_valid), 32'h1);
            chk("b2b_data", 32'(out_data), 32'(b2b_exp[i]));
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("b2b_drain", 32'(out_valid), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
